// File: rtl/lot_pkg.sv
// Shared types and constants for the lottery input-conditioning slice.
package lot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned BTN_INSERE   = 0;
  localparam int unsigned BTN_FIM      = 1;
  localparam int unsigned BTN_FIM_JOGO = 2;
  localparam int unsigned NUM_BTN      = 3;
  localparam int unsigned NUM_W        = 4;

endpackage

// File: rtl/lot_input_cond_btn_debounce.sv
// One button: polarity normalisation, 2-flop synchroniser, debounce FSM, press pulse.
// Auto-repeat while held is built only when BTN_REPEAT_EN is defined and REPEAT_EN is set.
module btn_debounce
  import lot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_raw_i,
  output logic press_o,
  output logic active_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             btn_n;
  logic             sync1_q;
  logic             btn_s_q;
  btn_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;
  logic             rep_hit;

  assign btn_n = ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      btn_s_q <= sync1_q;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [REP_W-1:0] rep_cnt_q;

  assign rep_hit = REPEAT_EN && (state_q == HELD) && btn_s_q &&
                   (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || !(REPEAT_EN && (state_q == HELD) && btn_s_q)) begin
      rep_cnt_q <= '0;
    end else if (rep_hit) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_q + REP_W'(1);
    end
  end
`else
  // Repeat parameters are still referenced so the default build carries no dangling ones.
  assign rep_hit = 1'b0 & REPEAT_EN & (REPEAT_CYCLES > 1);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (btn_s_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s_q) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CNT_W'(1);
          end else if (rep_hit) begin
            press_q <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_o  = press_q;
  assign active_o = (state_q != IDLE);

endmodule

// File: rtl/lot_input_cond.sv
// Input conditioning for the lottery FSM: three debounced buttons, arbitration, num capture.
// BTN_REPEAT_EN enables auto-repeat on the insere button.
module lot_input_cond
  import lot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned NUM_MAX         = 9,
  parameter int unsigned REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             insere_raw,
  input  logic             fim_raw,
  input  logic             fim_jogo_raw,
  input  logic [NUM_W-1:0] num_raw,
  output logic             insere,
  output logic             fim,
  output logic             fim_jogo,
  output logic [NUM_W-1:0] num,
  output logic             num_valid,
  output logic             busy
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] active;
  logic [NUM_W-1:0]   num_s1_q;
  logic [NUM_W-1:0]   num_s2_q;
  logic [NUM_W-1:0]   num_q;
  logic               num_valid_q;
  logic               busy_q;

  assign raw[BTN_INSERE]   = insere_raw;
  assign raw[BTN_FIM]      = fim_raw;
  assign raw[BTN_FIM_JOGO] = fim_jogo_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW),
      .REPEAT_EN      (i == BTN_INSERE),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_btn (
      .clk_i    (clk),
      .reset_i  (reset),
      .btn_raw_i(raw[i]),
      .press_o  (press[i]),
      .active_o (active[i])
    );
  end

  // Fixed priority fim_jogo > fim > insere; losers are simply dropped.
  assign fim_jogo = press[BTN_FIM_JOGO];
  assign fim      = press[BTN_FIM] & ~press[BTN_FIM_JOGO];
  assign insere   = press[BTN_INSERE] & ~press[BTN_FIM] & ~press[BTN_FIM_JOGO];

  always_ff @(posedge clk) begin
    if (reset) begin
      num_s1_q    <= '0;
      num_s2_q    <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      num_s1_q <= num_raw;
      num_s2_q <= num_s1_q;
      busy_q   <= |active;
      if (insere) begin
        num_q       <= num_s2_q;
        num_valid_q <= (32'(num_s2_q) <= NUM_MAX);
      end
    end
  end

  assign num       = num_q;
  assign num_valid = num_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lot_input_cond.sv
// Bench for lot_input_cond: segment table, hand-written corner sequences, random vs. run-length model.
module tb_lot_input_cond;

  localparam int D    = 4;
  localparam int R    = 8;
  localparam int NMAX = 9;
`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       insere_raw = 1'b1, fim_raw = 1'b1, fim_jogo_raw = 1'b1;
  logic [3:0] num_raw = 4'd0;
  logic       insere, fim, fim_jogo, num_valid, busy;
  logic [3:0] num;

  int checks = 0;
  int errors = 0;
  int cnt_i, cnt_f, cnt_j;

  always #5 clk = ~clk;

  lot_input_cond #(
    .DEBOUNCE_CYCLES(D),
    .BTN_ACTIVE_LOW (1'b1),
    .NUM_MAX        (NMAX),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .insere_raw  (insere_raw),
    .fim_raw     (fim_raw),
    .fim_jogo_raw(fim_jogo_raw),
    .num_raw     (num_raw),
    .insere      (insere),
    .fim         (fim),
    .fim_jogo    (fim_jogo),
    .num         (num),
    .num_valid   (num_valid),
    .busy        (busy)
  );

  // Reference: each button accepts a level change once the synchronised level has
  // disagreed with the accepted level for D consecutive samples.
  logic [2:0] m_s1, m_s2, m_acc, m_p, m_np;
  int         m_run[3];
  int         m_h;
  logic [3:0] m_n1, m_n2, m_num;
  logic       m_nv, m_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_p = '0; m_h = 0;
      m_n1 = '0; m_n2 = '0; m_num = '0; m_nv = 1'b1; m_busy = 1'b0;
      for (int b = 0; b < 3; b++) m_run[b] = 0;
    end else begin
      m_busy = (m_acc != 3'b000) || (m_run[0] > 0) || (m_run[1] > 0) || (m_run[2] > 0);
      if (m_p[0] && !m_p[1] && !m_p[2]) begin
        m_num = m_n2;
        m_nv  = (int'(m_n2) <= NMAX);
      end
      m_np = '0;
      if (REP && m_acc[0] && m_run[0] == 0 && m_s2[0]) begin
        m_h++;
        if (m_h == R) begin
          m_np[0] = 1'b1;
          m_h = 0;
        end
      end else begin
        m_h = 0;
      end
      for (int b = 0; b < 3; b++) begin
        if (m_s2[b] != m_acc[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_acc[b] = ~m_acc[b];
            m_run[b] = 0;
            if (m_acc[b]) m_np[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_p  = m_np;
      m_s2 = m_s1;
      m_s1 = ~{fim_jogo_raw, fim_raw, insere_raw};
      m_n2 = m_n1;
      m_n1 = num_raw;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [8:0] exp_v;
    @(posedge clk);
    #1;
    exp_v = {m_p[0] & ~m_p[1] & ~m_p[2], m_p[1] & ~m_p[2], m_p[2], m_num, m_nv, m_busy};
    check("model{ins,fim,fj,num,nv,busy}",
          32'({insere, fim, fim_jogo, num, num_valid, busy}), 32'(exp_v));
    cnt_i += int'(insere);
    cnt_f += int'(fim);
    cnt_j += int'(fim_jogo);
  endtask

  typedef struct {
    logic       ins, fm, fj;
    logic [3:0] nr;
    int         cyc;
    int         ei, ef, ej;
    logic [3:0] en;
    logic       ev, eb;
  } seg_t;

  seg_t tbl[13];

  task automatic apply_seg(input int idx, input seg_t s);
    insere_raw = s.ins; fim_raw = s.fm; fim_jogo_raw = s.fj; num_raw = s.nr;
    cnt_i = 0; cnt_f = 0; cnt_j = 0;
    repeat (s.cyc) tick();
    check($sformatf("seg%0d_insere_pulses", idx), 32'(cnt_i), 32'(s.ei));
    check($sformatf("seg%0d_fim_pulses", idx), 32'(cnt_f), 32'(s.ef));
    check($sformatf("seg%0d_fim_jogo_pulses", idx), 32'(cnt_j), 32'(s.ej));
    check($sformatf("seg%0d_num_nv_busy", idx), 32'({num, num_valid, busy}),
          32'({s.en, s.ev, s.eb}));
  endtask

  initial begin
    int first, second;
    // raw buttons are active-low: 0 = pressed
    tbl[0]  = '{1, 1, 1, 4'd7,  5,  0, 0, 0, 4'd0,  1, 0};
    tbl[1]  = '{0, 1, 1, 4'd7,  10, 1, 0, 0, 4'd7,  1, 1};
    tbl[2]  = '{1, 1, 1, 4'd7,  10, 0, 0, 0, 4'd7,  1, 0};
    tbl[3]  = '{0, 1, 1, 4'd12, 10, 1, 0, 0, 4'd12, 0, 1};
    tbl[4]  = '{1, 1, 1, 4'd3,  10, 0, 0, 0, 4'd12, 0, 0};
    tbl[5]  = '{0, 0, 1, 4'd5,  10, 0, 1, 0, 4'd12, 0, 1};
    tbl[6]  = '{1, 1, 1, 4'd5,  10, 0, 0, 0, 4'd12, 0, 0};
    tbl[7]  = '{0, 0, 0, 4'd2,  10, 0, 0, 1, 4'd12, 0, 1};
    tbl[8]  = '{1, 1, 1, 4'd2,  10, 0, 0, 0, 4'd12, 0, 0};
    tbl[9]  = '{0, 1, 1, 4'd6,  10, 1, 0, 0, 4'd6,  1, 1};
    tbl[10] = '{1, 1, 1, 4'd6,  3,  0, 0, 0, 4'd6,  1, 1};
    tbl[11] = '{0, 1, 1, 4'd6,  5,  0, 0, 0, 4'd6,  1, 1};
    tbl[12] = '{1, 1, 1, 4'd6,  10, 0, 0, 0, 4'd6,  1, 0};
    cnt_i = 0; cnt_f = 0; cnt_j = 0;

    repeat (3) tick();
    check("reset_outputs", 32'({insere, fim, fim_jogo, num, num_valid, busy}),
          32'({3'b000, 4'd0, 1'b1, 1'b0}));
    reset = 1'b0;

    for (int i = 0; i < 13; i++) apply_seg(i, tbl[i]);

    // Fast bouncing never qualifies as a press.
    cnt_i = 0;
    for (int i = 0; i < 10; i++) begin
      insere_raw = 1'b0; repeat (2) tick();
      insere_raw = 1'b1; repeat (2) tick();
    end
    repeat (10) tick();
    check("bounce_no_pulse", 32'(cnt_i), 32'd0);
    check("bounce_busy_idle", 32'(busy), 32'd0);

    // Reset during PRESS_WAIT with the button still held.
    insere_raw = 1'b0; num_raw = 4'd8;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    check("midreset_outputs", 32'({insere, fim, fim_jogo, num, num_valid, busy}),
          32'({3'b000, 4'd0, 1'b1, 1'b0}));
    reset = 1'b0;
    first = -1; second = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (insere) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("midreset_first_pulse_cycle", 32'(first), 32'(D + 2));
`ifdef BTN_REPEAT_EN
    check("midreset_repeat_gap", 32'(second - first), 32'(R));
`else
    check("midreset_no_repeat", 32'(second), 32'(-1));
`endif
    check("midreset_num_captured", 32'({num, num_valid}), 32'({4'd8, 1'b1}));
    insere_raw = 1'b1;
    repeat (12) tick();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) insere_raw = ~insere_raw;
      if ($urandom_range(5) == 0) fim_raw = ~fim_raw;
      if ($urandom_range(6) == 0) fim_jogo_raw = ~fim_jogo_raw;
      if ($urandom_range(7) == 0) num_raw = 4'($urandom);
      reset = ($urandom_range(399) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
